// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Funct3 encodings, FSM states and the iteration count.
package muldiv_pkg;

  localparam int ITERATIONS = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the
// multiply/divide unit.
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [2:0]            Funct3;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  Flush;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] MulDivResult;

  modport master (
    output Start, Funct3, SrcA, SrcB, Flush,
    input  Busy, Done, MulDivResult
  );

  modport slave (
    input  Start, Funct3, SrcA, SrcB, Flush,
    output Busy, Done, MulDivResult
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and
// restoring divide sharing one 2W accumulator and one adder.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic   clk,
  input logic   reset,
  muldiv_if.slave bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2*W-1:0]   acc, acc_nxt;
  logic [W-1:0]     mcand;
  logic [2:0]       op;
  logic             qneg, rneg, spec;
  logic [W-1:0]     result, fin;
  logic             busy, done, busy_nxt;

  logic             sa, sb, a_neg, b_neg, is_div;
  logic             div0, ovf, special;
  logic [W-1:0]     a_mag, b_mag, spec_val;
  logic [W:0]       opa, opb;
  logic [W+1:0]     sum;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     quo, rem;
  logic             last;

  // Request decode: operand signedness, magnitudes, special cases
  always_comb begin
    is_div = bus.Funct3[2];
    sa = (bus.Funct3 == MD_MULH) || (bus.Funct3 == MD_MULHSU) ||
         (bus.Funct3 == MD_DIV)  || (bus.Funct3 == MD_REM);
    sb = (bus.Funct3 == MD_MULH) || (bus.Funct3 == MD_DIV) ||
         (bus.Funct3 == MD_REM);
    a_neg = sa & bus.SrcA[W-1];
    b_neg = sb & bus.SrcB[W-1];
    a_mag = a_neg ? -bus.SrcA : bus.SrcA;
    b_mag = b_neg ? -bus.SrcB : bus.SrcB;
    div0 = is_div && (bus.SrcB == '0);
    ovf  = ((bus.Funct3 == MD_DIV) || (bus.Funct3 == MD_REM)) &&
           (bus.SrcA == {1'b1, {(W-1){1'b0}}}) &&
           (bus.SrcB == '1);
    special  = div0 || ovf;
    spec_val = '0;
    if (div0)
      spec_val = bus.Funct3[1] ? bus.SrcA : '1;
    else if (ovf)
      spec_val = bus.Funct3[1] ? '0 : bus.SrcA;
  end

  // One iteration: shared adder adds or subtracts the latched operand
  always_comb begin
    if (op[2]) begin
      opa = acc[2*W-1:W-1];
      opb = ~{1'b0, mcand};
    end else begin
      opa = {1'b0, acc[2*W-1:W]};
      opb = {1'b0, acc[0] ? mcand : '0};
    end
    sum = {1'b0, opa} + {1'b0, opb} + (W+2)'(op[2]);
    if (!op[2])
      acc_nxt = {sum[W:0], acc[W-1:1]};
    else if (sum[W+1])
      acc_nxt = {sum[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_nxt = {opa[W-1:0], acc[W-2:0], 1'b0};
  end

  // Final result with sign fix-up, taken from the last iteration
  always_comb begin
    prod = qneg ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[W-1:0];
    rem  = acc_nxt[2*W-1:W];
    fin  = '0;
    unique case (op)
      MD_MUL:                     fin = prod[W-1:0];
      MD_MULH, MD_MULHSU,
      MD_MULHU:                   fin = prod[2*W-1:W];
      MD_DIV, MD_DIVU:            fin = qneg ? -quo : quo;
      MD_REM, MD_REMU:            fin = rneg ? -rem : rem;
      default:                    fin = '0;
    endcase
  end

  // Next-state and registered-output decode
  always_comb begin
    last      = (cnt == CW'(W-1));
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.Start && !bus.Flush) state_nxt = RUN;
      RUN: begin
        if (bus.Flush)          state_nxt = IDLE;
        else if (spec || last)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == RUN) &&
               !((state == IDLE) ? special : spec);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      op     <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      spec   <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= (state_nxt == DONE);
      if (state == IDLE) begin
        if (bus.Start && !bus.Flush) begin
          op    <= bus.Funct3;
          cnt   <= '0;
          qneg  <= a_neg ^ b_neg;
          rneg  <= a_neg;
          spec  <= special;
          mcand <= is_div ? b_mag : a_mag;
          if (special)
            acc <= {{W{1'b0}}, spec_val};
          else
            acc <= {{W{1'b0}}, is_div ? a_mag : b_mag};
        end
      end else if (state == RUN) begin
        if (!bus.Flush && !spec) begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        if (state_nxt == DONE)
          result <= spec ? acc[W-1:0] : fin;
      end
    end
  end

  assign bus.Busy         = busy;
  assign bus.Done         = done;
  assign bus.MulDivResult = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Latency, results, flush, held Start and reset recovery.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  muldiv_if #(.DATA_WIDTH(32)) bus();

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic issue(
    input  logic [2:0]  f,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          hold,
    output logic [31:0] res,
    output int          lat,
    output int          bhi,
    output int          blo,
    output int          both
  );
    @(posedge clk);
    @(negedge clk);
    bus.Funct3 = f;
    bus.SrcA = a;
    bus.SrcB = b;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.Start = 1'b0;
    end else begin
      bus.Funct3 = 3'b101;
      bus.SrcA = 32'h1234_5678;
      bus.SrcB = 32'h0;
    end
    lat = 0;
    bhi = 0;
    blo = 0;
    both = 0;
    while (!bus.Done && lat < 40) begin
      if (bus.Busy) bhi++;
      else blo++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.Busy && bus.Done) both++;
    bus.Start = 1'b0;
    res = bus.MulDivResult;
    if (!bus.Done) lat = -1;
  endtask

  task automatic test_reset();
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    bus.Funct3 = 3'b000;
    bus.SrcA = '0;
    bus.SrcB = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.Busy);
    end
    checks++;
    if (bus.Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", bus.Done);
    end
    checks++;
    if (bus.MulDivResult !== 32'h0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=0",
               bus.MulDivResult);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b%b exp=00",
               bus.Busy, bus.Done);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f[4];
    logic [31:0] a[4], b[4], e[4];
    logic [31:0] res;
    int lat, bhi, blo, both;
    f[0] = MD_MUL;    a[0] = 32'd7;
    b[0] = 32'hFFFF_FFFD; e[0] = 32'hFFFF_FFEB;
    f[1] = MD_MULHU;  a[1] = 32'hFFFF_FFFF;
    b[1] = 32'hFFFF_FFFF; e[1] = 32'hFFFF_FFFE;
    f[2] = MD_MULH;   a[2] = 32'hFFFF_FFFF;
    b[2] = 32'hFFFF_FFFF; e[2] = 32'h0000_0000;
    f[3] = MD_MULHSU; a[3] = 32'hFFFF_FFFF;
    b[3] = 32'd2;         e[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 1'b0, res, lat, bhi, blo, both);
      checks++;
      if (res !== e[i]) begin
        failures++;
        $display("FAIL mul[%0d] result got=%h exp=%h",
                 i, res, e[i]);
      end
      checks++;
      if (lat !== ITERATIONS || bhi !== ITERATIONS ||
          blo !== 0 || both !== 0) begin
        failures++;
        $display("FAIL mul[%0d] timing lat=%0d busy=%0d/%0d ov=%0d exp 32 32/0 0",
                 i, lat, bhi, blo, both);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f[4];
    logic [31:0] a[4], b[4], e[4];
    logic [31:0] res;
    int lat, bhi, blo, both;
    f[0] = MD_DIV;  a[0] = 32'hFFFF_FFF9;
    b[0] = 32'd2;   e[0] = 32'hFFFF_FFFD;
    f[1] = MD_REM;  a[1] = 32'hFFFF_FFF9;
    b[1] = 32'd2;   e[1] = 32'hFFFF_FFFF;
    f[2] = MD_DIVU; a[2] = 32'd100;
    b[2] = 32'd7;   e[2] = 32'd14;
    f[3] = MD_REMU; a[3] = 32'd100;
    b[3] = 32'd7;   e[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 1'b0, res, lat, bhi, blo, both);
      checks++;
      if (res !== e[i]) begin
        failures++;
        $display("FAIL div[%0d] result got=%h exp=%h",
                 i, res, e[i]);
      end
      checks++;
      if (lat !== ITERATIONS || bhi !== ITERATIONS ||
          blo !== 0 || both !== 0) begin
        failures++;
        $display("FAIL div[%0d] timing lat=%0d busy=%0d/%0d ov=%0d exp 32 32/0 0",
                 i, lat, bhi, blo, both);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f[4];
    logic [31:0] a[4], b[4], e[4];
    logic [31:0] res;
    int lat, bhi, blo, both;
    f[0] = MD_DIVU; a[0] = 32'd5;
    b[0] = 32'd0;   e[0] = 32'hFFFF_FFFF;
    f[1] = MD_REM;  a[1] = 32'd5;
    b[1] = 32'd0;   e[1] = 32'd5;
    f[2] = MD_DIV;  a[2] = 32'h8000_0000;
    b[2] = 32'hFFFF_FFFF; e[2] = 32'h8000_0000;
    f[3] = MD_REM;  a[3] = 32'h8000_0000;
    b[3] = 32'hFFFF_FFFF; e[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 1'b0, res, lat, bhi, blo, both);
      checks++;
      if (res !== e[i]) begin
        failures++;
        $display("FAIL special[%0d] result got=%h exp=%h",
                 i, res, e[i]);
      end
      checks++;
      if (lat !== 1 || bhi !== 0 || both !== 0) begin
        failures++;
        $display("FAIL special[%0d] timing lat=%0d busy=%0d ov=%0d exp 1 0 0",
                 i, lat, bhi, both);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, bhi, blo, both;
    int seen;
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0, res, lat, bhi, blo, both);
    checks++;
    if (res !== 32'd14) begin
      failures++;
      $display("FAIL flush_pre result got=%h exp=%h", res, 32'd14);
    end
    @(posedge clk);
    @(negedge clk);
    bus.Funct3 = MD_DIV;
    bus.SrcA = 32'd1000;
    bus.SrcB = 32'd3;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy got=%b%b exp=00", bus.Busy, bus.Done);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done || bus.Busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL flush_no_done got=%0d exp=0", seen);
    end
    checks++;
    if (bus.MulDivResult !== 32'd14) begin
      failures++;
      $display("FAIL flush_hold result got=%h exp=%h",
               bus.MulDivResult, 32'd14);
    end
    @(negedge clk);
    bus.Funct3 = MD_MUL;
    bus.SrcA = 32'd3;
    bus.SrcB = 32'd5;
    bus.Start = 1'b1;
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done || bus.Busy) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0 || bus.MulDivResult !== 32'd14) begin
      failures++;
      $display("FAIL flush_start_idle act=%0d res=%h exp=0 %h",
               seen, bus.MulDivResult, 32'd14);
    end
  endtask

  task automatic test_hold_start();
    logic [31:0] res;
    int lat, bhi, blo, both;
    issue(MD_MULHU, 32'h8000_0000, 32'd4, 1'b1,
          res, lat, bhi, blo, both);
    checks++;
    if (res !== 32'd2) begin
      failures++;
      $display("FAIL hold result got=%h exp=%h", res, 32'd2);
    end
    checks++;
    if (lat !== ITERATIONS || bhi !== ITERATIONS) begin
      failures++;
      $display("FAIL hold timing lat=%0d busy=%0d exp 32 32",
               lat, bhi);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, bhi, blo, both;
    issue(MD_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0,
          res, lat, bhi, blo, both);
    issue(MD_REMU, 32'd100, 32'd7, 1'b0,
          res, lat, bhi, blo, both);
    checks++;
    if (res !== 32'd2 || lat !== ITERATIONS) begin
      failures++;
      $display("FAIL b2b got=%h lat=%0d exp=%h lat=32",
               res, lat, 32'd2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bhi, blo, both;
    int seen;
    @(posedge clk);
    @(negedge clk);
    bus.Funct3 = MD_MUL;
    bus.SrcA = 32'h1234;
    bus.SrcB = 32'h5678;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 ||
        bus.MulDivResult !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid got=%b%b %h exp=00 0",
               bus.Busy, bus.Done, bus.MulDivResult);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done || bus.Busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%0d exp=0", seen);
    end
    issue(MD_MUL, 32'd3, 32'd4, 1'b0, res, lat, bhi, blo, both);
    checks++;
    if (res !== 32'd12 || lat !== ITERATIONS) begin
      failures++;
      $display("FAIL reset_recover got=%h lat=%0d exp=%h lat=32",
               res, lat, 32'd12);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
